// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline boundary.
//
// Every cycle the decoder's control bundle and the datapath operands are
// captured into the ID/EX register. A load in EX whose destination is read by
// the instruction in decode stalls fetch/decode for one cycle and inserts a
// bubble. A taken branch or jump resolved in EX (PCSrcE) squashes the
// instruction in decode and turns the next EX slot into a bubble.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   *D inputs           decode-stage control, operands and register indices
//   OpcodeD             only used to decide which source registers are read
//   PCSrcE              taken branch/jump resolved in EX this cycle
//   *E outputs          registered EX-stage copies of the *D inputs
//   ValidE              EX holds a real instruction (0 for reset or bubble)
//   StallF, StallD      hold PC and IF/ID register (load-use hazard)
//   FlushD              squash the IF/ID register (taken branch/jump)
//   StallCount          saturating count of load-use bubbles since reset
//
// Stall/flush semantics: StallF/StallD/FlushD are combinational from the
// current EX register and the decode inputs. A stall holds the upstream stages
// for exactly the cycle in which it is asserted; a flush always overrides a
// stall in the same cycle, so a squashed instruction never causes a bubble.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [6:0]      OpcodeD,
  input  logic            RegWriteD,
  input  logic            ALUSrcAD,
  input  logic            ALUSrcBD,
  input  logic            MemWriteD,
  input  logic            BranchD,
  input  logic [3:0]      ALUControlD,
  input  logic [1:0]      ResultSrcD,
  input  logic [2:0]      BranchTypeD,
  input  logic [2:0]      AddressingControlD,
  input  logic [1:0]      JumpD,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic [4:0]      RdD,
  input  logic            PCSrcE,
  output logic            RegWriteE,
  output logic            ALUSrcAE,
  output logic            ALUSrcBE,
  output logic            MemWriteE,
  output logic            BranchE,
  output logic [3:0]      ALUControlE,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      BranchTypeE,
  output logic [2:0]      AddressingControlE,
  output logic [1:0]      JumpE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic            ValidE,
  output logic            StallF,
  output logic            StallD,
  output logic            FlushD,
  output logic [CNT_W-1:0] StallCount
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [1:0] RES_MEM   = 2'b01;

  typedef struct packed {
    logic            reg_write;
    logic            alu_src_a;
    logic            alu_src_b;
    logic            mem_write;
    logic            branch;
    logic [3:0]      alu_control;
    logic [1:0]      result_src;
    logic [2:0]      branch_type;
    logic [2:0]      addr_control;
    logic [1:0]      jump;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } id_ex_t;

  id_ex_t          id_ex_q, id_ex_d, decode_bundle;
  logic            valid_e_q, valid_e_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic uses_rs1, uses_rs2;
  logic load_use_hazard;

  // Unknown opcodes fall into the default: Rs1 assumed read, Rs2 not. This
  // can only add stalls, never miss one for a real Rs1 consumer.
  always_comb begin
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    case (OpcodeD)
      OP_LUI, OP_AUIPC, OP_JAL:        uses_rs1 = 1'b0;
      OP_RTYPE, OP_STORE, OP_BRANCH:   uses_rs2 = 1'b1;
      default: ;
    endcase
  end

  // x0 is never a real dependency, so a load into x0 does not stall.
  always_comb begin
    load_use_hazard = valid_e_q
                    && (id_ex_q.result_src == RES_MEM)
                    && (id_ex_q.rd != 5'd0)
                    && ((uses_rs1 && (Rs1D == id_ex_q.rd))
                     || (uses_rs2 && (Rs2D == id_ex_q.rd)));
  end

  assign StallF = load_use_hazard & ~PCSrcE;
  assign StallD = load_use_hazard & ~PCSrcE;
  assign FlushD = PCSrcE;

  always_comb begin
    decode_bundle = '{
      reg_write:    RegWriteD,
      alu_src_a:    ALUSrcAD,
      alu_src_b:    ALUSrcBD,
      mem_write:    MemWriteD,
      branch:       BranchD,
      alu_control:  ALUControlD,
      result_src:   ResultSrcD,
      branch_type:  BranchTypeD,
      addr_control: AddressingControlD,
      jump:         JumpD,
      rd1:          RD1D,
      rd2:          RD2D,
      imm_ext:      ImmExtD,
      pc:           PCD,
      pc_plus4:     PCPlus4D,
      rs1:          Rs1D,
      rs2:          Rs2D,
      rd:           RdD
    };
  end

  // A bubble clears the whole bundle, which also leaves every control
  // field inert (no register write, no store, no branch, no jump).
  always_comb begin
    id_ex_d     = decode_bundle;
    valid_e_d   = 1'b1;
    stall_cnt_d = stall_cnt_q;
    if (PCSrcE) begin
      id_ex_d   = '0;
      valid_e_d = 1'b0;
    end else if (load_use_hazard) begin
      id_ex_d   = '0;
      valid_e_d = 1'b0;
      if (stall_cnt_q != {CNT_W{1'b1}}) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_q     <= '0;
      valid_e_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      id_ex_q     <= id_ex_d;
      valid_e_q   <= valid_e_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign RegWriteE          = id_ex_q.reg_write;
  assign ALUSrcAE           = id_ex_q.alu_src_a;
  assign ALUSrcBE           = id_ex_q.alu_src_b;
  assign MemWriteE          = id_ex_q.mem_write;
  assign BranchE            = id_ex_q.branch;
  assign ALUControlE        = id_ex_q.alu_control;
  assign ResultSrcE         = id_ex_q.result_src;
  assign BranchTypeE        = id_ex_q.branch_type;
  assign AddressingControlE = id_ex_q.addr_control;
  assign JumpE              = id_ex_q.jump;
  assign RD1E               = id_ex_q.rd1;
  assign RD2E               = id_ex_q.rd2;
  assign ImmExtE            = id_ex_q.imm_ext;
  assign PCE                = id_ex_q.pc;
  assign PCPlus4E           = id_ex_q.pc_plus4;
  assign Rs1E               = id_ex_q.rs1;
  assign Rs2E               = id_ex_q.rs2;
  assign RdE                = id_ex_q.rd;
  assign ValidE             = valid_e_q;
  assign StallCount         = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: a full-size instance and a CNT_W=2 instance
// share all inputs. The driver applies directed then random decode inputs and
// pushes the expected results into queues; a monitor on the falling edge pops
// and compares whatever is due that cycle.
module tb_id_ex_stage;

  localparam int XLEN = 32;
  localparam int BW   = 195;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst;
  logic [6:0] OpcodeD;
  logic RegWriteD, ALUSrcAD, ALUSrcBD, MemWriteD, BranchD;
  logic [3:0] ALUControlD;
  logic [1:0] ResultSrcD;
  logic [2:0] BranchTypeD, AddressingControlD;
  logic [1:0] JumpD;
  logic [XLEN-1:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic PCSrcE;

  logic RegWriteE, ALUSrcAE, ALUSrcBE, MemWriteE, BranchE;
  logic [3:0] ALUControlE;
  logic [1:0] ResultSrcE;
  logic [2:0] BranchTypeE, AddressingControlE;
  logic [1:0] JumpE;
  logic [XLEN-1:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0] Rs1E, Rs2E, RdE;
  logic ValidE, StallF, StallD, FlushD;
  logic [15:0] StallCount;

  logic RegWriteE_s, ALUSrcAE_s, ALUSrcBE_s, MemWriteE_s, BranchE_s;
  logic [3:0] ALUControlE_s;
  logic [1:0] ResultSrcE_s;
  logic [2:0] BranchTypeE_s, AddressingControlE_s;
  logic [1:0] JumpE_s;
  logic [XLEN-1:0] RD1E_s, RD2E_s, ImmExtE_s, PCE_s, PCPlus4E_s;
  logic [4:0] Rs1E_s, Rs2E_s, RdE_s;
  logic ValidE_s, StallF_s, StallD_s, FlushD_s;
  logic [1:0] StallCount_s;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .OpcodeD(OpcodeD),
    .RegWriteD(RegWriteD), .ALUSrcAD(ALUSrcAD), .ALUSrcBD(ALUSrcBD),
    .MemWriteD(MemWriteD), .BranchD(BranchD), .ALUControlD(ALUControlD),
    .ResultSrcD(ResultSrcD), .BranchTypeD(BranchTypeD),
    .AddressingControlD(AddressingControlD), .JumpD(JumpD),
    .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .PCSrcE(PCSrcE),
    .RegWriteE(RegWriteE), .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE),
    .MemWriteE(MemWriteE), .BranchE(BranchE), .ALUControlE(ALUControlE),
    .ResultSrcE(ResultSrcE), .BranchTypeE(BranchTypeE),
    .AddressingControlE(AddressingControlE), .JumpE(JumpE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ValidE(ValidE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .StallCount(StallCount)
  );

  id_ex_stage #(.XLEN(XLEN), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .OpcodeD(OpcodeD),
    .RegWriteD(RegWriteD), .ALUSrcAD(ALUSrcAD), .ALUSrcBD(ALUSrcBD),
    .MemWriteD(MemWriteD), .BranchD(BranchD), .ALUControlD(ALUControlD),
    .ResultSrcD(ResultSrcD), .BranchTypeD(BranchTypeD),
    .AddressingControlD(AddressingControlD), .JumpD(JumpD),
    .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .PCSrcE(PCSrcE),
    .RegWriteE(RegWriteE_s), .ALUSrcAE(ALUSrcAE_s), .ALUSrcBE(ALUSrcBE_s),
    .MemWriteE(MemWriteE_s), .BranchE(BranchE_s), .ALUControlE(ALUControlE_s),
    .ResultSrcE(ResultSrcE_s), .BranchTypeE(BranchTypeE_s),
    .AddressingControlE(AddressingControlE_s), .JumpE(JumpE_s),
    .RD1E(RD1E_s), .RD2E(RD2E_s), .ImmExtE(ImmExtE_s), .PCE(PCE_s), .PCPlus4E(PCPlus4E_s),
    .Rs1E(Rs1E_s), .Rs2E(Rs2E_s), .RdE(RdE_s), .ValidE(ValidE_s),
    .StallF(StallF_s), .StallD(StallD_s), .FlushD(FlushD_s), .StallCount(StallCount_s)
  );

  logic [BW-1:0] act_e, act_e_s;
  assign act_e = {RegWriteE, ALUSrcAE, ALUSrcBE, MemWriteE, BranchE, ALUControlE,
                  ResultSrcE, BranchTypeE, AddressingControlE, JumpE,
                  RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, ValidE};
  assign act_e_s = {RegWriteE_s, ALUSrcAE_s, ALUSrcBE_s, MemWriteE_s, BranchE_s, ALUControlE_s,
                    ResultSrcE_s, BranchTypeE_s, AddressingControlE_s, JumpE_s,
                    RD1E_s, RD2E_s, ImmExtE_s, PCE_s, PCPlus4E_s, Rs1E_s, Rs2E_s, RdE_s, ValidE_s};

  // ---------------- scoreboard ----------------
  // exp_q entry: {EX bundle incl. ValidE, 16-bit count, 2-bit count}
  logic [BW+17:0] exp_q[$];
  int             exp_due[$];
  logic [5:0]     comb_q[$];
  int             comb_due[$];
  int checks = 0;
  int errors = 0;

  // reference model: what instruction sits in EX, plus the bubble counts
  bit            m_known = 0;
  bit            m_valid = 0;
  bit            m_load  = 0;
  int            m_rd    = 0;
  logic [BW-1:0] m_bundle = '0;
  int            m_cnt16 = 0;
  int            m_cnt2  = 0;

  logic [6:0] op_tab [10];
  initial begin
    op_tab[0] = 7'b0110011; op_tab[1] = 7'b0010011; op_tab[2] = 7'b0000011;
    op_tab[3] = 7'b0100011; op_tab[4] = 7'b1100011; op_tab[5] = 7'b0110111;
    op_tab[6] = 7'b0010111; op_tab[7] = 7'b1101111; op_tab[8] = 7'b1100111;
    op_tab[9] = 7'b0000000;
  end

  // ---------------- driver tasks ----------------
  task automatic rand_d();
    int k;
    k = $urandom_range(0, 9);
    OpcodeD = (k == 9) ? 7'($urandom) : op_tab[k];
    RegWriteD = 1'($urandom); ALUSrcAD = 1'($urandom); ALUSrcBD = 1'($urandom);
    MemWriteD = 1'($urandom); BranchD = 1'($urandom);
    ALUControlD = 4'($urandom);
    ResultSrcD = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'($urandom);
    BranchTypeD = 3'($urandom); AddressingControlD = 3'($urandom);
    JumpD = 2'($urandom);
    RD1D = $urandom; RD2D = $urandom; ImmExtD = $urandom;
    PCD = $urandom; PCPlus4D = PCD + 32'd4;
    Rs1D = 5'($urandom_range(0, 7)); Rs2D = 5'($urandom_range(0, 7));
    RdD = 5'($urandom_range(0, 7));
  endtask

  task automatic set_instr(input logic [6:0] op, input int rs1, input int rs2,
                           input int rd, input logic [1:0] rsrc, input logic pcsrc);
    rand_d();
    OpcodeD = op; Rs1D = 5'(rs1); Rs2D = 5'(rs2); RdD = 5'(rd);
    ResultSrcD = rsrc; PCSrcE = pcsrc; rst = 1'b0;
  endtask

  // Called just after a rising edge with the decode inputs applied.
  task automatic step();
    bit u1, u2, haz;
    logic [2:0] c;
    u1 = !(OpcodeD == 7'b0110111 || OpcodeD == 7'b0010111 || OpcodeD == 7'b1101111);
    u2 = (OpcodeD == 7'b0110011 || OpcodeD == 7'b0100011 || OpcodeD == 7'b1100011);
    haz = m_valid && m_load && (m_rd != 0) &&
          ((u1 && (int'(Rs1D) == m_rd)) || (u2 && (int'(Rs2D) == m_rd)));
    if (m_known) begin
      c = {haz && !PCSrcE, haz && !PCSrcE, PCSrcE};
      comb_q.push_back({c, c});
      comb_due.push_back(cyc);
    end
    if (rst) begin
      m_valid = 0; m_load = 0; m_rd = 0; m_bundle = '0; m_cnt16 = 0; m_cnt2 = 0;
    end else if (PCSrcE || haz) begin
      m_valid = 0; m_load = 0; m_rd = 0; m_bundle = '0;
      if (!PCSrcE) begin
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end else begin
      m_valid = 1; m_load = (ResultSrcD == 2'b01); m_rd = int'(RdD);
      m_bundle = {RegWriteD, ALUSrcAD, ALUSrcBD, MemWriteD, BranchD, ALUControlD,
                  ResultSrcD, BranchTypeD, AddressingControlD, JumpD,
                  RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD, 1'b1};
    end
    exp_q.push_back({m_bundle, 16'(m_cnt16), 2'(m_cnt2)});
    exp_due.push_back(cyc + 1);
    m_known = 1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [BW+17:0] e;
    logic [5:0] cx;
    while (comb_due.size() > 0 && comb_due[0] == cyc) begin
      void'(comb_due.pop_front());
      cx = comb_q.pop_front();
      checks++;
      if ({StallF, StallD, FlushD, StallF_s, StallD_s, FlushD_s} !== cx) begin
        errors++;
        $display("FAIL stall_flush cyc=%0d actual=%b expected=%b", cyc,
                 {StallF, StallD, FlushD, StallF_s, StallD_s, FlushD_s}, cx);
      end
    end
    while (exp_due.size() > 0 && exp_due[0] == cyc) begin
      void'(exp_due.pop_front());
      e = exp_q.pop_front();
      checks++;
      if ({act_e, StallCount} !== e[BW+17:2]) begin
        errors++;
        $display("FAIL ex_reg_main cyc=%0d actual=%h expected=%h", cyc,
                 {act_e, StallCount}, e[BW+17:2]);
      end
      checks++;
      if ({act_e_s, StallCount_s} !== {e[BW+17:18], e[1:0]}) begin
        errors++;
        $display("FAIL ex_reg_sat2 cyc=%0d actual=%h expected=%h", cyc,
                 {act_e_s, StallCount_s}, {e[BW+17:18], e[1:0]});
      end
    end
  end

  localparam logic [6:0] R_OP = 7'b0110011, I_OP = 7'b0010011, LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011, LUI = 7'b0110111;

  // ---------------- stimulus ----------------
  initial begin
    // reset with non-zero decode inputs
    rand_d(); RegWriteD = 1'b1; RdD = 5'd9; PCSrcE = 1'b0; rst = 1'b1;
    step();
    rand_d(); RegWriteD = 1'b1; RdD = 5'd9; PCSrcE = 1'b0; rst = 1'b1;
    step();
    // addi x3,x1,5
    set_instr(I_OP, 1, 0, 3, 2'b00, 1'b0);
    RegWriteD = 1'b1; ALUSrcBD = 1'b1; ImmExtD = 32'd5;
    step();
    // lw x5 ; add x6,x5,x1 (stall, bubble, then capture)
    set_instr(LD, 1, 0, 5, 2'b01, 1'b0); step();
    set_instr(R_OP, 5, 1, 6, 2'b00, 1'b0); step(); step();
    // lw x0 with consumer of x0
    set_instr(LD, 1, 0, 0, 2'b01, 1'b0); step();
    set_instr(R_OP, 0, 2, 7, 2'b00, 1'b0); step();
    // lw x5 ; lui whose rs1 field is 5
    set_instr(LD, 1, 0, 5, 2'b01, 1'b0); step();
    set_instr(LUI, 5, 5, 8, 2'b00, 1'b0); step();
    // lw x5 ; addi whose rs2 field is 5
    set_instr(LD, 1, 0, 5, 2'b01, 1'b0); step();
    set_instr(I_OP, 1, 5, 9, 2'b00, 1'b0); step();
    // flush of a sw, then flush concurrent with a hazard pattern
    set_instr(ST, 2, 3, 0, 2'b00, 1'b1); MemWriteD = 1'b1; step();
    set_instr(LD, 1, 0, 5, 2'b01, 1'b0); step();
    set_instr(ST, 5, 5, 0, 2'b00, 1'b1); MemWriteD = 1'b1; step();
    // five load-use hazards: 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      set_instr(LD, 1, 0, 5, 2'b01, 1'b0); step();
      set_instr(R_OP, 5, 1, 6, 2'b00, 1'b0); step();
    end
    // back-to-back dependent loads
    set_instr(LD, 1, 0, 5, 2'b01, 1'b0); step();
    set_instr(LD, 5, 0, 6, 2'b01, 1'b0); step(); step();
    set_instr(LD, 6, 0, 7, 2'b01, 1'b0); step(); step();
    // reset asserted while a stall is pending
    set_instr(R_OP, 7, 1, 4, 2'b00, 1'b0); rst = 1'b1; step();
    set_instr(R_OP, 7, 1, 4, 2'b00, 1'b0); step();
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rand_d();
      PCSrcE = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0; PCSrcE = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || comb_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained actual=%0d/%0d expected=0/0", exp_q.size(), comb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute boundary of the pipelined core. Captures the decoder's control bundle and the register-file/immediate datapath values into the ID/EX pipeline register each cycle. Detects load-use hazards against the instruction currently in EX and flushes EX when a taken branch or jump resolves. On a load-use hazard it generates fetch/decode stalls and inserts a bubble.

## Interface
Parameters:
- XLEN, 32, datapath width
- CNT_W, 16, width of the saturating stall counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- OpcodeD  in  7  opcode of the decode-stage instruction; used only for source-register usage
- RegWriteD, ALUSrcAD, ALUSrcBD, MemWriteD, BranchD  in  1 each  decoder control
- ALUControlD  in  4  decoder ALU operation
- ResultSrcD  in  2  write-back select; 01 = memory
- BranchTypeD, AddressingControlD  in  3 each  branch condition / load-store width
- JumpD  in  2  00 none, 01 JAL, 10 JALR
- RD1D, RD2D, ImmExtD, PCD, PCPlus4D  in  XLEN each  datapath operands
- Rs1D, Rs2D, RdD  in  5 each  register indices
- PCSrcE  in  1  taken branch or jump resolved in EX this cycle
- all the above with suffix E (RegWriteE … RdE)  out  same widths  registered EX-stage copies
- ValidE  out  1  EX holds a real instruction
- StallF, StallD  out  1  hold PC and IF/ID register
- FlushD  out  1  squash the IF/ID register
- StallCount  out  CNT_W  number of load-use bubbles since reset, saturating

## Operation
- Source usage derived from OpcodeD:
  - Rs1 used unless the opcode is LUI (0110111), AUIPC (0010111) or JAL (1101111).
  - Rs2 used only for R-type (0110011), store (0100011) and branch (1100011).
- Load-use hazard: ValidE & (ResultSrcE == 01) & (RdE != 0) & ((usesRs1 & Rs1D == RdE) | (usesRs2 & Rs2D == RdE)).
- StallF = StallD = hazard & ~PCSrcE.
- FlushD = PCSrcE.
- Register update priority, highest first:
  1. rst: all E outputs 0, ValidE 0, StallCount 0.
  2. PCSrcE: bubble. All E outputs 0 and ValidE 0; control fields are then inert (RegWriteE = MemWriteE = BranchE = 0, JumpE = 00).
  3. Hazard: bubble as above; StallCount increments by 1 unless it is all-ones, where it holds.
  4. Otherwise: capture every D input into its E output; ValidE 1.
- Any OpcodeD value not listed under source usage is treated as using Rs1 only. This is conservative and may cause spurious stalls, never missed ones.
- No internal state other than the pipeline register and StallCount.

## Timing
- Capture latency: D inputs sampled at edge N appear on the E outputs after edge N.
- StallF, StallD and FlushD are combinational from the current E register and the D inputs, valid within the same cycle.
- A load-use hazard produces exactly one bubble. On the following cycle the load has moved to MEM, ValidE = 0, the hazard clears, and the held instruction is captured.
- PCSrcE and hazard asserted together: the flush wins, stalls are suppressed, and StallCount does not increment.
- Reset asserted mid-stall: the next state is the full reset state; StallF and StallD drop once ValidE = 0.
- Back-to-back loads where each feeds the next: one bubble per dependent pair.

## Test plan
- Reset: hold rst for 2 cycles with non-zero D inputs -> all E outputs 0, ValidE 0, StallCount 0, StallF/StallD/FlushD 0.
- Pass-through: addi x3,x1,5 in D (RegWriteD 1, ALUSrcBD 1, ImmExtD 5, RdD 3) -> next cycle RegWriteE 1, ImmExtE 5, RdE 3, ValidE 1; no stall.
- Load-use: lw x5 in EX (ResultSrcE 01, RdE 5), add x6,x5,x1 in D -> StallF = StallD = 1 that cycle. Next cycle ValidE 0, RegWriteE 0, StallCount 1. Following cycle the add is captured (RdE 6).
- No false stall: lw x0 in EX with consumer Rs1D 0 -> no stall. lw x5 in EX with LUI in D whose Rs1 field is 5 -> no stall. lw x5 in EX with addi in D whose Rs2 field is 5 -> no stall.
- Flush: PCSrcE 1 while D holds sw -> FlushD 1; next cycle MemWriteE 0, ValidE 0. Also with a hazard pattern forced concurrently -> StallF/StallD 0, StallCount unchanged.
- Saturation: CNT_W = 2, drive 5 load-use hazards -> StallCount reaches 3 and holds at 3.
